// File: rtl/seq_det_ctrl.sv
// Word-level controller for the serial pattern detector: accepts a word, shifts it
// MSB-first through a programmable overlapping matcher and reports the match count.
module seq_det_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              bit_o,
    output logic              det_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is registered, out_valid is a pure decode of the REPORT state.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b101);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  sr_q;
    logic [PAT_W-2:0]   hist_q;
    logic [FILL_W-1:0]  fill_q;
    logic [PAT_W-1:0]   pat_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               in_ready_q, in_ready_d;
    logic [PAT_W-1:0]   window;
    logic               accept, cfg_ok, fill_full, last_bit;

    assign accept    = (state_q == IDLE) && in_valid && in_ready_q;
    assign cfg_ok    = (state_q == IDLE) && cfg_we;
    assign fill_full = (fill_q == FILL_W'(PAT_W-1));
    assign last_bit  = (idx_q == IDX_W'(WORD_W-1));
    assign bit_o     = (state_q == SHIFT) && sr_q[WORD_W-1];
    assign window    = {hist_q, bit_o};
    assign det_o     = (state_q == SHIFT) && (window == pat_q) && fill_full;
    assign out_valid = (state_q == REPORT);
    assign out_cnt   = out_valid ? cnt_q : '0;
    assign in_ready  = in_ready_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        in_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_d = !accept;
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (last_bit) state_d = REPORT;
            end
            REPORT: begin
                in_ready_d = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // A cfg write and a word accept on the same edge both land; the word then
    // starts against the new pattern with an empty history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_RST;
            cnt_q  <= '0;
            idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_ok) begin
                        pat_q  <= cfg_pat;
                        hist_q <= '0;
                        fill_q <= '0;
                    end
                    if (accept) begin
                        sr_q  <= in_data;
                        cnt_q <= '0;
                        idx_q <= '0;
                    end
                end
                SHIFT: begin
                    sr_q   <= sr_q << 1;
                    hist_q <= window[PAT_W-2:0];
                    if (!fill_full) fill_q <= fill_q + 1'b1;
                    cnt_q  <= cnt_q + CNT_W'(det_o);
                    idx_q  <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl: detection, overlap, cross-word
// history, reconfiguration, backpressure and asynchronous reset.
module tb_seq_det_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_pat = 3'b000;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       bit_o, det_o, out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_cnt;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl #(.WORD_W(8), .PAT_W(3), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bit_o(bit_o), .det_o(det_o), .out_valid(out_valid), .out_ready(out_ready),
        .out_cnt(out_cnt), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        #1 reset_n = 1'b0;
        #3;
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic cfg_write(input logic [2:0] p);
        @(negedge clock);
        cfg_we = 1'b1; cfg_pat = p;
        @(posedge clock);
        #1 cfg_we = 1'b0;
    endtask

    // Runs one word; bits/dets are packed MSB = SHIFT cycle 1.
    task automatic do_word(input logic [7:0] w, input logic do_cfg, input logic [2:0] cp,
                           input logic mid_cfg, input logic hs,
                           output logic [7:0] bits, output logic [7:0] dets,
                           output logic [3:0] cnt);
        int n;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait got %b exp 1", in_ready);
        end
        in_valid = 1'b1; in_data = w; cfg_we = do_cfg; cfg_pat = cp;
        @(posedge clock);
        #1 in_valid = 1'b0; cfg_we = 1'b0;
        bits = '0; dets = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            bits[7-k] = bit_o;
            dets[7-k] = det_o;
            if (mid_cfg && k == 2) begin cfg_we = 1'b1; cfg_pat = 3'b000; end
            if (mid_cfg && k == 3) cfg_we = 1'b0;
            if (k == 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL out_valid_early got %b exp 0", out_valid);
                end
            end
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_latency got %b exp 1", out_valid);
        end
        cnt = out_cnt;
        if (hs) begin
            out_ready = 1'b1;
            @(posedge clock);
            #1 out_ready = 1'b0;
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL handshake_return got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({in_ready, out_valid, det_o, bit_o, out_cnt, dbg_state} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {in_ready, out_valid, det_o, bit_o, out_cnt, dbg_state});
        end
        @(negedge clock) reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_pre_edge got %b exp 0", in_ready);
        end
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_after_reset got %b exp 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] b, d;
        logic [3:0] c;
        do_word(8'b0101_0110, 1'b0, 3'b000, 1'b0, 1'b1, b, d, c);
        checks++;
        if (b !== 8'b0101_0110) begin errors++; $display("FAIL basic_bits got %b exp 01010110", b); end
        checks++;
        if (d !== 8'b0001_0100) begin errors++; $display("FAIL basic_det got %b exp 00010100", d); end
        checks++;
        if (c !== 4'd2) begin errors++; $display("FAIL basic_cnt got %0d exp 2", c); end
    endtask

    task automatic test_cross_word();
        logic [7:0] b, d;
        logic [3:0] c;
        do_word(8'b1000_0000, 1'b0, 3'b000, 1'b0, 1'b1, b, d, c);
        checks++;
        if (d !== 8'b1000_0000) begin errors++; $display("FAIL cross_det got %b exp 10000000", d); end
        checks++;
        if (c !== 4'd1) begin errors++; $display("FAIL cross_cnt got %0d exp 1", c); end
    endtask

    task automatic test_overlap();
        logic [7:0] b, d;
        logic [3:0] c;
        apply_reset();
        do_word(8'b1010_1010, 1'b0, 3'b000, 1'b0, 1'b1, b, d, c);
        checks++;
        if (d !== 8'b0010_1010) begin errors++; $display("FAIL overlap_det got %b exp 00101010", d); end
        checks++;
        if (c !== 4'd3) begin errors++; $display("FAIL overlap_cnt got %0d exp 3", c); end
    endtask

    task automatic test_reconfig();
        logic [7:0] b, d;
        logic [3:0] c;
        cfg_write(3'b111);
        do_word(8'hFF, 1'b0, 3'b000, 1'b0, 1'b1, b, d, c);
        checks++;
        if (d !== 8'b0011_1111) begin errors++; $display("FAIL cfg111_det got %b exp 00111111", d); end
        checks++;
        if (c !== 4'd6) begin errors++; $display("FAIL cfg111_cnt got %0d exp 6", c); end
        // History carries over, and the mid-shift write of 000 must be dropped.
        do_word(8'hFF, 1'b0, 3'b000, 1'b1, 1'b1, b, d, c);
        checks++;
        if (d !== 8'hFF) begin errors++; $display("FAIL cfg_in_shift_det got %b exp 11111111", d); end
        checks++;
        if (c !== 4'd8) begin errors++; $display("FAIL cfg_in_shift_cnt got %0d exp 8", c); end
        do_word(8'h00, 1'b1, 3'b000, 1'b0, 1'b1, b, d, c);
        checks++;
        if (d !== 8'b0011_1111) begin errors++; $display("FAIL cfg_accept_det got %b exp 00111111", d); end
        checks++;
        if (c !== 4'd6) begin errors++; $display("FAIL cfg_accept_cnt got %0d exp 6", c); end
    endtask

    task automatic test_backpressure();
        logic [7:0] b, d;
        logic [3:0] c;
        // Pattern 000 with full zero history: every bit of 8'h00 matches.
        do_word(8'h00, 1'b0, 3'b000, 1'b0, 1'b0, b, d, c);
        checks++;
        if (c !== 4'd8) begin errors++; $display("FAIL bp_cnt got %0d exp 8", c); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_data = 8'hAA;
            checks++;
            if (out_valid !== 1'b1 || out_cnt !== 4'd8 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got out_valid=%b out_cnt=%0d in_ready=%b exp 1/8/0",
                         i, out_valid, out_cnt, in_ready);
            end
        end
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b, d;
        logic [3:0] c;
        apply_reset();
        in_valid = 1'b1; in_data = 8'b1010_0000;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bit_o !== 1'b1 || det_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset got bit_o=%b det_o=%b exp 1/1", bit_o, det_o);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, det_o, bit_o, out_cnt, dbg_state} !== 10'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b exp 0", {in_ready, out_valid, det_o, bit_o, out_cnt, dbg_state});
        end
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);
        do_word(8'b0101_0110, 1'b0, 3'b000, 1'b0, 1'b1, b, d, c);
        checks++;
        if (d !== 8'b0001_0100) begin errors++; $display("FAIL mid_after_det got %b exp 00010100", d); end
        checks++;
        if (c !== 4'd2) begin errors++; $display("FAIL mid_after_cnt got %0d exp 2", c); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cross_word();
        test_overlap();
        test_reconfig();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
